// File: rtl/maria_arb_pkg.sv
// Shared types and defaults for the Sally/Maria bus arbiter.
package maria_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HALT_WAIT,
    SETTLE,
    GRANT,
    RELEASE
  } arb_state_t;

  localparam int DEF_HALT_SETTLE   = 2;
  localparam int DEF_RELEASE_GAP   = 1;
  localparam int DEF_WATCHDOG_MCLK = 1024;

  localparam logic [15:0] STEAL_SAT = 16'hFFFF;

  // Bits needed to hold values 0..n, never narrower than one bit.
  function automatic int bits_for(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/arb_steal_counter.sv
// Counts mclk0 strobes spent with the CPU halted; snapshots and restarts on vblank rise.
// Single-cycle update, no backpressure; a strobe on the vblank edge belongs to the new frame.
module arb_steal_counter
  import maria_arb_pkg::*;
(
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        mclk0,
  input  logic        halt_n,
  input  logic        vblank,
  output logic [15:0] steal_count
);

  logic [15:0] acc;
  logic        vblank_q;
  logic        strobe;
  logic        rise;

  assign strobe = mclk0 & ~halt_n;
  assign rise   = vblank & ~vblank_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      acc         <= '0;
      vblank_q    <= 1'b0;
      steal_count <= '0;
    end else begin
      vblank_q <= vblank;
      if (rise) begin
        steal_count <= acc;
        acc         <= {15'd0, strobe};
      end else if (strobe && acc != STEAL_SAT) begin
        acc <= acc + 16'd1;
      end
    end
  end

endmodule

// File: rtl/maria_bus_arbiter.sv
// Sally/Maria bus arbiter: HALT handshake, settle, grant, release with watchdog; halt_n/dma_grant one clk after decision.
// No backpressure: dma_req is a held level; ARB_STEAL_STATS_EN adds steal_count statistics.
module maria_bus_arbiter
  import maria_arb_pkg::*;
#(
  parameter int HALT_SETTLE   = DEF_HALT_SETTLE,
  parameter int RELEASE_GAP   = DEF_RELEASE_GAP,
  parameter int WATCHDOG_MCLK = DEF_WATCHDOG_MCLK
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        mclk0,
  input  logic        pclk1,
  input  logic        maria_en,
  input  logic        dma_req,
  input  logic        dma_done,
  input  logic [15:0] dma_addr,
  input  logic [15:0] cpu_addr,
  input  logic        vblank,
  output logic        halt_n,
  output logic        dma_grant,
  output logic        drive_ab,
  output logic [15:0] ab_out,
  output logic        wd_error,
  output logic        busy
`ifdef ARB_STEAL_STATS_EN
  ,
  output logic [15:0] steal_count
`endif
);

  localparam int CW = bits_for((HALT_SETTLE > RELEASE_GAP) ? HALT_SETTLE : RELEASE_GAP);
  localparam int WW = bits_for(WATCHDOG_MCLK);

  localparam logic [CW-1:0] SETTLE_LOAD  = CW'(HALT_SETTLE);
  localparam logic [CW-1:0] RELEASE_LOAD = CW'(RELEASE_GAP);
  localparam logic [WW-1:0] WD_LIMIT     = WW'(WATCHDOG_MCLK);

  arb_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [WW-1:0] wd, wd_nxt;
  logic          wd_error_nxt;

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    wd_nxt       = '0;
    wd_error_nxt = wd_error;
    case (state)
      IDLE: begin
        if (dma_req && maria_en) state_nxt = HALT_WAIT;
      end
      HALT_WAIT: begin
        if (pclk1) begin
          state_nxt = SETTLE;
          cnt_nxt   = SETTLE_LOAD;
        end
      end
      SETTLE: begin
        if (cnt == '0)  state_nxt = GRANT;
        else if (mclk0) cnt_nxt   = cnt - CW'(1);
      end
      GRANT: begin
        wd_nxt = wd;
        if (mclk0 && wd != WD_LIMIT) wd_nxt = wd + WW'(1);
        // A done arriving together with the watchdog limit is a clean finish.
        if (dma_done) begin
          state_nxt = RELEASE;
          cnt_nxt   = RELEASE_LOAD;
        end else if (wd == WD_LIMIT) begin
          state_nxt    = RELEASE;
          cnt_nxt      = RELEASE_LOAD;
          wd_error_nxt = 1'b1;
        end
      end
      RELEASE: begin
        if (cnt == '0)  state_nxt = IDLE;
        else if (mclk0) cnt_nxt   = cnt - CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
    if (!maria_en) state_nxt = IDLE;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      wd        <= '0;
      halt_n    <= 1'b1;
      dma_grant <= 1'b0;
      wd_error  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wd        <= wd_nxt;
      halt_n    <= (state_nxt == IDLE);
      dma_grant <= (state_nxt == GRANT);
      wd_error  <= wd_error_nxt;
    end
  end

  assign busy     = (state != IDLE);
  assign drive_ab = dma_grant & maria_en;
  assign ab_out   = dma_grant ? dma_addr : cpu_addr;

`ifdef ARB_STEAL_STATS_EN
  arb_steal_counter u_steal (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .mclk0       (mclk0),
    .halt_n      (halt_n),
    .vblank      (vblank),
    .steal_count (steal_count)
  );
`else
  logic vblank_unused;
  assign vblank_unused = vblank;
`endif

endmodule

// File: doc/maria_bus_arbiter.md
Name: maria_bus_arbiter

Overview:
- Shares the system address bus between the 6502 (Sally) CPU and the Maria DMA engine.
- Sequences the HALT handshake: accepts a DMA request, asserts halt at a legal CPU phase boundary, then grants the bus to DMA after a settle delay.
- Releases the bus on DMA completion, or forcibly on a watchdog timeout.
- Sits between the DMA engine, the clock generator (mclk/pclk strobes) and the top-level bus mux that drives AB_out/drive_AB.

Parameters:
- HALT_SETTLE, 2: mclk0 strobes between halt taking effect at a pclk1 boundary and DMA grant.
- RELEASE_GAP, 1: mclk0 strobes between DMA done and CPU bus ownership.
- WATCHDOG_MCLK, 1024: maximum mclk0 strobes in grant before forced release; width is $clog2(WATCHDOG_MCLK+1).

Ports:
- clk_sys  in  1  system clock (reset: reset, synchronous, active-high; clock clk_sys)
- reset  in  1  synchronous active-high reset
- mclk0  in  1  master-clock enable strobe, one clk_sys cycle wide
- pclk1  in  1  CPU phase-1 strobe; marks end of a CPU cycle
- maria_en  in  1  low = 2600 mode; arbiter idles and never halts
- dma_req  in  1  level request from DMA engine; held until granted
- dma_done  in  1  one-clk pulse, DMA finished with bus
- dma_addr  in  16  DMA address
- cpu_addr  in  16  CPU address
- vblank  in  1  frame marker for statistics
- halt_n  out  1  to CPU; low = halted
- dma_grant  out  1  DMA owns bus
- drive_ab  out  1  arbiter drives AB (grant & maria_en)
- ab_out  out  16  muxed address: dma_addr when granted, else cpu_addr
- wd_error  out  1  sticky; set on watchdog release, cleared by reset
- busy  out  1  state != IDLE

Behaviour:
- Reset values: halt_n=1, dma_grant=0, drive_ab=0, ab_out=cpu_addr (combinational mux), wd_error=0, busy=0, state=IDLE, all counters 0.
- FSM states: IDLE, HALT_WAIT, SETTLE, GRANT, RELEASE. Counters advance only on a clk_sys cycle with mclk0=1, except where pclk1 is stated.
- IDLE:
  - dma_req & maria_en → HALT_WAIT; halt_n drops the same clock edge (registered; low on the next cycle).
  - dma_req with maria_en=0 is ignored.
- HALT_WAIT: waits for the next pclk1 strobe (CPU completes its current cycle) → SETTLE, cnt=HALT_SETTLE.
- SETTLE: decrements on mclk0; at cnt==0 → GRANT; dma_grant=1 and drive_ab=1 from the next cycle.
- GRANT:
  - wd counts mclk0 strobes.
  - dma_done → RELEASE, cnt=RELEASE_GAP; dma_grant drops next cycle.
  - wd reaching WATCHDOG_MCLK → RELEASE, wd_error=1.
  - dma_done and watchdog on the same cycle: treat as normal done; wd_error not set.
- RELEASE:
  - Decrements on mclk0; at cnt==0: halt_n=1 and state → IDLE.
  - If dma_req is still high on IDLE entry, it is re-serviced on the next cycle. Minimum one idle cycle with halt_n=1 so the CPU can see a boundary.
- maria_en falling in any state: within one clock force IDLE, halt_n=1, dma_grant=0. wd_error is unchanged.
- Reset mid-GRANT: all outputs return to reset values on the next edge; dma_done pulses during reset are ignored.
- dma_done outside GRANT: ignored.
- ab_out is combinational: dma_grant ? dma_addr : cpu_addr.

Optional Feature:
- Macro ARB_STEAL_STATS_EN.
- When defined:
  - Adds output steal_count [15:0].
  - An internal counter increments per mclk0 strobe while halt_n=0, saturating at 16'hFFFF.
  - On the vblank rising edge, the counter value is latched to steal_count and the counter is cleared. If a strobe coincides with the edge, it is counted into the new frame.
- When undefined: no port, no logic.

Decomposition:
- Package maria_arb_pkg:
  - typedef enum logic [2:0] arb_state_t {IDLE, HALT_WAIT, SETTLE, GRANT, RELEASE}
  - localparams for default HALT_SETTLE, RELEASE_GAP, WATCHDOG_MCLK
- One natural sub-module, arb_steal_counter, holding the optional statistics logic; instantiated only under ARB_STEAL_STATS_EN.

Test Plan:
- Basic handshake: mclk0 every 2 clk, pclk1 every 8 clk, dma_req=1 → halt_n=0 one clk later; dma_grant=1 after next pclk1 + 2 mclk0; ab_out=dma_addr (16'h1F00) while granted.
- Done and release: dma_done pulse in GRANT → dma_grant=0 next clk; halt_n=1 after 1 mclk0; busy=0; ab_out=cpu_addr (16'hF000).
- Watchdog: WATCHDOG_MCLK=8, no dma_done → forced release after 8 mclk0 in GRANT; wd_error=1 and stays 1 through a following normal transaction.
- maria_en=0 mid-GRANT → halt_n=1, dma_grant=0, drive_ab=0 within 1 clk; dma_req while maria_en=0 → halt_n stays 1.
- Back-to-back: dma_req held high across RELEASE → exactly one cycle with halt_n=1 and state IDLE, then a new HALT_WAIT.
- ARB_STEAL_STATS_EN: 3 transactions of 10 halted mclk0 each, then vblank rise → steal_count equals the exact halted-strobe total computed by the bench model; the internal counter restarts at 0.
